// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the set-associative data cache.
// Used by dcache_sa_ctrl and dcache_sa_way.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } state_e;

    function automatic int offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_w,
                                 input int sets);
        return addr_w - offset_w(line_w) - index_w(sets);
    endfunction

    function automatic int words_per_line(input int line_w, input int data_w);
        return line_w / data_w;
    endfunction

endpackage

// File: rtl/dcache_sa_way.sv
// One cache way: per-set valid/dirty/tag/line storage, a tag compare,
// a line fill port and a single-word store port.
module dcache_sa_way
    import dcache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    parameter int DATA_W = 32,
    parameter int WSEL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    output logic              hit_o,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              fill_i,
    input  logic [IDX_W-1:0]  fill_idx_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              store_i,
    input  logic [WSEL_W-1:0] store_word_i,
    input  logic [DATA_W-1:0] store_data_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    assign valid_o = valid_q[rd_idx_i];
    assign dirty_o = dirty_q[rd_idx_i];
    assign tag_o   = tag_q[rd_idx_i];
    assign line_o  = line_q[rd_idx_i];
    assign hit_o   = valid_o && (tag_o == rd_tag_i);

    // Status bits: fill makes a line valid and clean, a store dirties it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[fill_idx_i] <= 1'b1;
            dirty_q[fill_idx_i] <= 1'b0;
        end else if (store_i) begin
            dirty_q[rd_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            line_q[fill_idx_i] <= fill_line_i;
        end else if (store_i) begin
            line_q[rd_idx_i][store_word_i*DATA_W +: DATA_W] <= store_data_i;
        end
    end

endmodule

// File: rtl/dcache_sa_ctrl.sv
// Set-associative write-back data cache controller with round-robin
// replacement. Optional hit/miss/write-back counters: DCACHE_STATS_EN.
module dcache_sa_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
`endif
);

    localparam int OFF_W  = offset_w(LINE_W);
    localparam int IDX_W  = index_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
    localparam int WORDS  = words_per_line(LINE_W, DATA_W);
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BSEL_W = $clog2(DATA_W / 8);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              req;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_addr;

    assign req  = p1_MemRead_i | p1_MemWrite_i;
    assign idx  = p1_addr_i[OFF_W +: IDX_W];
    assign tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel = p1_addr_i[BSEL_W +: WSEL_W];
    assign unused_addr = ^p1_addr_i[BSEL_W-1:0];

    state_e                     state_q;
    logic [WAY_W-1:0]           victim_q;
    logic [TAG_W-1:0]           miss_tag_q;
    logic [IDX_W-1:0]           miss_idx_q;
    logic                       mem_en_q;
    logic                       mem_wr_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [LINE_W-1:0]          mem_data_q;
    logic [SETS-1:0][WAY_W-1:0] ptr_q;

    logic [WAYS-1:0]   way_hit;
    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_dirty;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vic;
    logic             store_hit;
    logic             miss;
    logic             fill_ack;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_sa_way #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W),
            .DATA_W (DATA_W),
            .WSEL_W (WSEL_W)
        ) u_way (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .rd_idx_i     (idx),
            .rd_tag_i     (tag),
            .hit_o        (way_hit[w]),
            .valid_o      (way_valid[w]),
            .dirty_o      (way_dirty[w]),
            .tag_o        (way_tag[w]),
            .line_o       (way_line[w]),
            .fill_i       (fill_ack && (victim_q == WAY_W'(w))),
            .fill_idx_i   (miss_idx_q),
            .fill_tag_i   (miss_tag_q),
            .fill_line_i  (mem_data_i),
            .store_i      (store_hit && (hit_way == WAY_W'(w))),
            .store_word_i (wsel),
            .store_data_i (p1_data_i)
        );
    end

    // Hit detection and victim choice: lowest invalid way, else pointer
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic     = ptr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) vic = WAY_W'(w);
        end
    end

    assign store_hit = (state_q == IDLE) && p1_MemWrite_i && hit;
    assign miss      = (state_q == IDLE) && req && !hit;
    assign fill_ack  = (state_q == FILL) && mem_ack_i;

    assign p1_data_o  = (req && hit) ?
                        way_line[hit_way][wsel*DATA_W +: DATA_W] : '0;
    assign p1_stall_o = (state_q != IDLE) || (req && !hit);

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Miss FSM with registered memory-side outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        victim_q   <= vic;
                        miss_tag_q <= tag;
                        miss_idx_q <= idx;
                        mem_en_q   <= 1'b1;
                        if (way_valid[vic] && way_dirty[vic]) begin
                            state_q    <= WB;
                            mem_wr_q   <= 1'b1;
                            mem_addr_q <= {way_tag[vic], idx, {OFF_W{1'b0}}};
                            mem_data_q <= way_line[vic];
                        end else begin
                            state_q    <= FILL;
                            mem_wr_q   <= 1'b0;
                            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WB: begin
                    if (mem_ack_i) begin
                        state_q    <= FILL;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        state_q  <= DONE;
                        mem_en_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Round-robin pointer moves only when the pointed way was refilled
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
        end else if (fill_ack && (WAYS > 1) &&
                     (victim_q == ptr_q[miss_idx_q])) begin
            ptr_q[miss_idx_q] <= victim_q + WAY_W'(1);
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [31:0] wb_cnt_q;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if ((state_q == IDLE) && req && hit && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if ((state_q == WB) && mem_ack_i && (wb_cnt_q != '1))
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// Self-checking bench for dcache_sa_ctrl with a 3-cycle-ack memory model
// and a load-data scoreboard; checks counters when DCACHE_STATS_EN is set.
module tb_dcache_sa_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic         p1_rd;
    logic         p1_wr;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_en;
    logic         mem_we;
    logic         mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
    logic [31:0]  wb_cnt;
`endif

    always #5 clk = ~clk;

    dcache_sa_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_addr_i     (p1_addr),
        .p1_data_i     (p1_wdata),
        .p1_MemRead_i  (p1_rd),
        .p1_MemWrite_i (p1_wr),
        .p1_data_o     (p1_rdata),
        .p1_stall_o    (p1_stall),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_data_i    (mem_rdata),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_we),
        .mem_ack_i     (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt),
        .wb_cnt_o      (wb_cnt)
`endif
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    int           errors = 0;
    int           checks = 0;
    int           en_cycles = 0;
    int           m_hits = 0;
    int           m_miss = 0;
    int           m_wb = 0;
    txn_t         log_q[$];
    logic [31:0]  exp_q[$];
    logic [255:0] mem_m [logic [31:0]];

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = a + 32'(w * 4) + 32'h1000_0000;
        return l;
    endfunction

    // Memory model: ack pulse on the third cycle of an enable
    initial begin
        int   cnt;
        txn_t t;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_en) begin
                en_cycles++;
                cnt++;
                if (cnt == 3) begin
                    t.wr = mem_we;
                    t.addr = mem_addr;
                    t.data = mem_wdata;
                    if (mem_we) begin
                        mem_m[mem_addr] = mem_wdata;
                    end else if (mem_m.exists(mem_addr)) begin
                        mem_rdata = mem_m[mem_addr];
                    end else begin
                        mem_rdata = line_of(mem_addr);
                    end
                    log_q.push_back(t);
                    mem_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic first,
                          output logic [31:0] rdata);
        @(negedge clk);
        p1_addr = a;
        p1_wdata = d;
        p1_rd = rd;
        p1_wr = wr;
        #1;
        first = p1_stall;
        stalls = 0;
        while (p1_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (p1_stall) stalls = -1;
        rdata = p1_rdata;
        @(posedge clk);
        #1;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        p1_addr = '0;
        p1_wdata = '0;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_en got=%b want=0", mem_en);
        end
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_we got=%b want=0", mem_we);
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mem_addr got=%h want=0", mem_addr);
        end
        checks++;
        if (mem_wdata !== 256'h0) begin
            errors++;
            $display("FAIL rst_mem_data got=%h want=0", mem_wdata);
        end
        checks++;
        if (p1_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall got=%b want=0", p1_stall);
        end
        checks++;
        if (p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata got=%h want=0", p1_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_load();
        int          st;
        logic        f;
        logic [31:0] rd;
        logic [31:0] e;
        txn_t        t;
        log_q.delete();
        exp_q.push_back(32'h1000_0040);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, st, f, rd);
        m_hits++;
        m_miss++;
        e = exp_q.pop_front();
        checks++;
        if (f !== 1'b1) begin
            errors++;
            $display("FAIL cold_stall_same_cycle got=%b want=1", f);
        end
        checks++;
        if (st != 5) begin
            errors++;
            $display("FAIL cold_stall_cycles got=%0d want=5", st);
        end
        checks++;
        if (rd !== e) begin
            errors++;
            $display("FAIL cold_data got=%h want=%h", rd, e);
        end
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL cold_txn_count got=%0d want=1", log_q.size());
        end else begin
            t = log_q.pop_front();
            checks++;
            if (t.wr !== 1'b0 || t.addr !== 32'h40) begin
                errors++;
                $display("FAIL cold_fill got=wr%b@%h want=wr0@00000040",
                         t.wr, t.addr);
            end
        end
    endtask

    task automatic test_store_hit();
        int          st;
        int          n;
        logic        f;
        logic [31:0] rd;
        logic [31:0] e;
        log_q.delete();
        n = en_cycles;
        do_req(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, st, f, rd);
        m_hits++;
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL store_hit_stall got=%0d want=0", st);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h44, 32'h0, st, f, rd);
        m_hits++;
        e = exp_q.pop_front();
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL load_hit_stall got=%0d want=0", st);
        end
        checks++;
        if (rd !== e) begin
            errors++;
            $display("FAIL load_hit_data got=%h want=%h", rd, e);
        end
        checks++;
        if (en_cycles != n || log_q.size() != 0) begin
            errors++;
            $display("FAIL hit_no_mem got=%0d want=%0d", en_cycles, n);
        end
    endtask

    task automatic test_evict();
        int           st;
        logic         f;
        logic [31:0]  rd;
        logic [31:0]  e;
        logic [255:0] el;
        txn_t         t;
        log_q.delete();
        exp_q.push_back(32'h1000_0240);
        do_req(1'b1, 1'b0, 32'h240, 32'h0, st, f, rd);
        m_hits++;
        m_miss++;
        e = exp_q.pop_front();
        checks++;
        if (st != 5 || rd !== e) begin
            errors++;
            $display("FAIL ld240 got=%0d/%h want=5/%h", st, rd, e);
        end
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL ld240_txns got=%0d want=1", log_q.size());
        end else begin
            t = log_q.pop_front();
            checks++;
            if (t.wr !== 1'b0 || t.addr !== 32'h240) begin
                errors++;
                $display("FAIL ld240_fill got=wr%b@%h want=wr0@00000240",
                         t.wr, t.addr);
            end
        end
        log_q.delete();
        exp_q.push_back(32'h1000_0440);
        do_req(1'b1, 1'b0, 32'h440, 32'h0, st, f, rd);
        m_hits++;
        m_miss++;
        m_wb++;
        e = exp_q.pop_front();
        checks++;
        if (st != 9 || rd !== e) begin
            errors++;
            $display("FAIL ld440 got=%0d/%h want=9/%h", st, rd, e);
        end
        el = line_of(32'h40);
        el[63:32] = 32'hDEAD_BEEF;
        checks++;
        if (log_q.size() != 2) begin
            errors++;
            $display("FAIL ld440_txns got=%0d want=2", log_q.size());
        end else begin
            t = log_q.pop_front();
            checks++;
            if (t.wr !== 1'b1 || t.addr !== 32'h40) begin
                errors++;
                $display("FAIL wb_addr got=wr%b@%h want=wr1@00000040",
                         t.wr, t.addr);
            end
            checks++;
            if (t.data[63:32] !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL wb_word1 got=%h want=deadbeef", t.data[63:32]);
            end
            checks++;
            if (t.data !== el) begin
                errors++;
                $display("FAIL wb_line got=%h want=%h", t.data, el);
            end
            t = log_q.pop_front();
            checks++;
            if (t.wr !== 1'b0 || t.addr !== 32'h440) begin
                errors++;
                $display("FAIL ld440_fill got=wr%b@%h want=wr0@00000440",
                         t.wr, t.addr);
            end
        end
        log_q.delete();
        exp_q.push_back(32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h44, 32'h0, st, f, rd);
        m_hits++;
        m_miss++;
        e = exp_q.pop_front();
        checks++;
        if (st != 5 || rd !== e) begin
            errors++;
            $display("FAIL reload44 got=%0d/%h want=5/%h", st, rd, e);
        end
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL reload44_txns got=%0d want=1", log_q.size());
        end
    endtask

    task automatic test_rw_both();
        int          st;
        int          n;
        logic        f;
        logic [31:0] rd;
        logic [31:0] e;
        exp_q.push_back(32'h1000_0080);
        do_req(1'b1, 1'b0, 32'h80, 32'h0, st, f, rd);
        m_hits++;
        m_miss++;
        e = exp_q.pop_front();
        checks++;
        if (st != 5 || rd !== e) begin
            errors++;
            $display("FAIL ld80 got=%0d/%h want=5/%h", st, rd, e);
        end
        n = en_cycles;
        do_req(1'b1, 1'b1, 32'h80, 32'h1234, st, f, rd);
        m_hits++;
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL rw80_stall got=%0d want=0", st);
        end
        exp_q.push_back(32'h0000_1234);
        do_req(1'b1, 1'b0, 32'h80, 32'h0, st, f, rd);
        m_hits++;
        e = exp_q.pop_front();
        checks++;
        if (st != 0 || rd !== e) begin
            errors++;
            $display("FAIL rw80_load got=%0d/%h want=0/%h", st, rd, e);
        end
        checks++;
        if (en_cycles != n) begin
            errors++;
            $display("FAIL rw80_no_mem got=%0d want=%0d", en_cycles, n);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        checks++;
        if (hit_cnt !== 32'(m_hits)) begin
            errors++;
            $display("FAIL hit_cnt got=%0d want=%0d", hit_cnt, m_hits);
        end
        checks++;
        if (miss_cnt !== 32'(m_miss)) begin
            errors++;
            $display("FAIL miss_cnt got=%0d want=%0d", miss_cnt, m_miss);
        end
        checks++;
        if (wb_cnt !== 32'(m_wb)) begin
            errors++;
            $display("FAIL wb_cnt got=%0d want=%0d", wb_cnt, m_wb);
        end
    endtask
`endif

    task automatic test_reset_mid_fill();
        int          st;
        logic        f;
        logic        seen;
        logic [31:0] rd;
        logic [31:0] e;
        seen = 1'b0;
        @(negedge clk);
        p1_addr = 32'h640;
        p1_rd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL midfill_enable got=%b want=1", seen);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midfill_reset got=%b@%h want=0@00000000",
                     mem_en, mem_addr);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0 || wb_cnt !== 32'h0) begin
            errors++;
            $display("FAIL stats_clear got=%0d/%0d/%0d want=0/0/0",
                     hit_cnt, miss_cnt, wb_cnt);
        end
`endif
        p1_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        log_q.delete();
        exp_q.push_back(32'h1000_0240);
        do_req(1'b1, 1'b0, 32'h240, 32'h0, st, f, rd);
        e = exp_q.pop_front();
        checks++;
        if (st != 5 || rd !== e) begin
            errors++;
            $display("FAIL post_rst_240 got=%0d/%h want=5/%h", st, rd, e);
        end
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL post_rst_txns got=%0d want=1", log_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_evict();
        test_rw_both();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_fill();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
